// File: rtl/sram_lsu_ctrl.sv
// Load/store front-end for a word-addressed 32-bit SRAM macro: decodes byte/half/word
// requests into lane enables and replicated write data, and aligns/extends load data.
module sram_lsu_ctrl #(
  parameter int          DEPTH         = 128,
  parameter int          ADDR_W        = 7,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          READ_LATENCY  = 2,
  parameter int          WRITE_LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic [ADDR_W-1:0] sram_addr_sel_o,
  output logic [3:0]        sram_byte_sel_o,
  output logic              sram_read_enable_o,
  output logic              sram_write_enable_o,
  output logic [31:0]       sram_datain_o,
  input  logic [31:0]       sram_dataout_i
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [31:0] RANGE = 32'(4 * DEPTH);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, RESP} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         lane_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic               ready_q;
  logic               resp_valid_q;
  logic [31:0]        resp_rdata_q;
  logic               resp_err_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [3:0]         bsel_q;
  logic               re_q;
  logic               we_q;
  logic [31:0]        din_q;

  logic [31:0]        off_d;
  logic               err_d;
  logic [3:0]         bsel_d;
  logic [31:0]        din_d;
  logic [31:0]        shifted_d;
  logic [31:0]        fmt_d;

  assign off_d = req_addr_i - BASE_ADDR;
  assign err_d = (req_size_i == 2'b11)
               | ((req_size_i == 2'b01) & off_d[0])
               | ((req_size_i == 2'b10) & (|off_d[1:0]))
               | (req_addr_i < BASE_ADDR)
               | (off_d >= RANGE);

  always_comb begin
    bsel_d = 4'b1111;
    din_d  = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        bsel_d = 4'b0001 << off_d[1:0];
        din_d  = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        bsel_d = 4'b0011 << off_d[1:0];
        din_d  = {2{req_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load data is aligned by the captured byte offset, then narrowed and extended.
  always_comb begin
    shifted_d = sram_dataout_i >> {lane_q, 3'b000};
    fmt_d     = shifted_d;
    case (size_q)
      2'b00:   fmt_d = uns_q ? {24'b0, shifted_d[7:0]}  : {{24{shifted_d[7]}}, shifted_d[7:0]};
      2'b01:   fmt_d = uns_q ? {16'b0, shifted_d[15:0]} : {{16{shifted_d[15]}}, shifted_d[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lane_q       <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      addr_q       <= '0;
      bsel_q       <= '0;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
      din_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (req_valid_i && ready_q) begin
            ready_q <= 1'b0;
            lane_q  <= off_d[1:0];
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            if (err_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              addr_q <= off_d[ADDR_W+1:2];
              bsel_q <= bsel_d;
              if (req_we_i) begin
                state_q <= WRITE;
                we_q    <= 1'b1;
                din_q   <= din_d;
                cnt_q   <= CNT_W'(WRITE_LATENCY - 1);
              end else begin
                state_q <= READ;
                re_q    <= 1'b1;
                cnt_q   <= CNT_W'(READ_LATENCY - 1);
              end
            end
          end
        end
        WRITE: begin
          if (cnt_q == '0) begin
            we_q         <= 1'b0;
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        READ: begin
          if (cnt_q == '0) begin
            re_q    <= 1'b0;
            state_q <= CAPTURE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        CAPTURE: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= fmt_d;
        end
        RESP: begin
          state_q      <= IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          addr_q       <= '0;
          bsel_q       <= '0;
          din_q        <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o         = ready_q;
  assign resp_valid_o        = resp_valid_q;
  assign resp_rdata_o        = resp_rdata_q;
  assign resp_err_o          = resp_err_q;
  assign sram_addr_sel_o     = addr_q;
  assign sram_byte_sel_o     = bsel_q;
  assign sram_read_enable_o  = re_q;
  assign sram_write_enable_o = we_q;
  assign sram_datain_o       = din_q;

endmodule

// File: tb/tb_sram_lsu_ctrl.sv
// Bench for sram_lsu_ctrl: a behavioural SRAM plus a byte-array reference memory
// predicts responses, lane enables and timing for directed and random traffic.
module tb_sram_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [6:0]  sram_addr_sel;
  logic [3:0]  sram_byte_sel;
  logic        sram_read_enable, sram_write_enable;
  logic [31:0] sram_datain, sram_dataout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_lsu_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .sram_addr_sel_o(sram_addr_sel), .sram_byte_sel_o(sram_byte_sel),
    .sram_read_enable_o(sram_read_enable), .sram_write_enable_o(sram_write_enable),
    .sram_datain_o(sram_datain), .sram_dataout_i(sram_dataout)
  );

  // Behavioural SRAM macro with registered read data
  logic [31:0] sramMem [0:127];
  always @(posedge clk) begin
    if (sram_write_enable)
      for (int i = 0; i < 4; i++)
        if (sram_byte_sel[i]) sramMem[sram_addr_sel][8*i +: 8] <= sram_datain[8*i +: 8];
    if (sram_read_enable) sram_dataout <= sramMem[sram_addr_sel];
  end

  logic [7:0] refMem [0:511];

  int          obsLat, obsWe, obsRe;
  logic [6:0]  obsAddr;
  logic [3:0]  obsBsel;
  logic [31:0] obsDin, obsRdata;
  logic        obsErr, obsStable, obsOverlap;

  function automatic int nBytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit expErr(input logic [31:0] addr, input logic [1:0] size);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
           (size == 2'd2 && addr % 4 != 0) || (addr >= 32'd512);
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] addr, input logic [1:0] size, input bit uns);
    int n;
    longint v;
    n = nBytes(size);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(refMem[addr + i]) << (8 * i));
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] expBsel(input logic [31:0] addr, input logic [1:0] size);
    logic [3:0] b;
    b = 4'b0000;
    for (int i = 0; i < nBytes(size); i++) b[(addr + i) % 4] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] expDin(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'd0) return {4{w[7:0]}};
    if (size == 2'd1) return {2{w[15:0]}};
    return w;
  endfunction

  task automatic refStore(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] w);
    for (int i = 0; i < nBytes(size); i++) refMem[addr + i] = w[8*i +: 8];
  endtask

  // Issues one request, then watches every cycle until the response strobe
  task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [1:0] size,
                               input bit uns, input logic [31:0] wdata);
    int  k;
    bit  first;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    obsLat = 99; obsWe = 0; obsRe = 0; obsStable = 1'b1; obsOverlap = 1'b0;
    obsAddr = '0; obsBsel = '0; obsDin = '0; obsRdata = '0; obsErr = 1'b0;
    first = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (sram_write_enable) obsWe++;
      if (sram_read_enable) obsRe++;
      if (sram_read_enable && sram_write_enable) obsOverlap = 1'b1;
      if (sram_read_enable || sram_write_enable) begin
        if (first) begin
          obsAddr = sram_addr_sel; obsBsel = sram_byte_sel; obsDin = sram_datain; first = 1'b0;
        end else if (obsAddr !== sram_addr_sel || obsBsel !== sram_byte_sel || obsDin !== sram_datain) begin
          obsStable = 1'b0;
        end
      end
      if (resp_valid) begin
        obsLat = c; obsRdata = resp_rdata; obsErr = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = 32'hA5A5A5A5;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, resp_rdata, sram_addr_sel, sram_byte_sel, sram_datain} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs: got ready=%b rv=%b err=%b rdata=%h addr=%h bsel=%b din=%h want all 0",
                         req_ready, resp_valid, resp_err, resp_rdata, sram_addr_sel, sram_byte_sel, sram_datain);
    end
    checks++;
    if ({sram_read_enable, sram_write_enable} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_enables: got re=%b we=%b want 0 0", sram_read_enable, sram_write_enable);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_store_load();
    applyStimulus(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
    refStore(32'h10, 2'd2, 32'hDEADBEEF);
    checks++;
    if (obsWe !== 2 || obsAddr !== 7'd4 || obsBsel !== 4'b1111 || obsLat !== 3 || obsStable !== 1'b1) begin
      errors++; $display("[TB] FAIL st_word: got we=%0d addr=%0d bsel=%b lat=%0d stable=%b want 2 4 1111 3 1",
                         obsWe, obsAddr, obsBsel, obsLat, obsStable);
    end
    applyStimulus(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    checks++;
    if (obsRdata !== 32'hDEADBEEF || obsLat !== 4 || obsRe !== 2) begin
      errors++; $display("[TB] FAIL ld_word: got %h lat=%0d re=%0d want deadbeef 4 2", obsRdata, obsLat, obsRe);
    end
    applyStimulus(1'b1, 32'h13, 2'd0, 1'b0, 32'h00000080);
    refStore(32'h13, 2'd0, 32'h80);
    checks++;
    if (obsBsel !== 4'b1000 || obsDin !== 32'h80808080) begin
      errors++; $display("[TB] FAIL st_byte: got bsel=%b din=%h want 1000 80808080", obsBsel, obsDin);
    end
    applyStimulus(1'b0, 32'h13, 2'd0, 1'b0, 32'h0);
    checks++;
    if (obsRdata !== 32'hFFFFFF80) begin
      errors++; $display("[TB] FAIL ld_byte_signed: got %h want ffffff80", obsRdata);
    end
    applyStimulus(1'b0, 32'h13, 2'd0, 1'b1, 32'h0);
    checks++;
    if (obsRdata !== 32'h00000080) begin
      errors++; $display("[TB] FAIL ld_byte_unsigned: got %h want 00000080", obsRdata);
    end
    applyStimulus(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    checks++;
    if (obsRdata !== 32'h80ADBEEF) begin
      errors++; $display("[TB] FAIL ld_word_merged: got %h want 80adbeef", obsRdata);
    end
    applyStimulus(1'b1, 32'h22, 2'd1, 1'b0, 32'h00001234);
    refStore(32'h22, 2'd1, 32'h1234);
    checks++;
    if (obsBsel !== 4'b1100 || obsDin !== 32'h12341234) begin
      errors++; $display("[TB] FAIL st_half: got bsel=%b din=%h want 1100 12341234", obsBsel, obsDin);
    end
    applyStimulus(1'b0, 32'h22, 2'd1, 1'b0, 32'h0);
    checks++;
    if (obsRdata !== 32'h00001234) begin
      errors++; $display("[TB] FAIL ld_half_signed: got %h want 00001234", obsRdata);
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [4];
    logic [1:0]  sizes [4];
    addrs = '{32'h02, 32'h05, 32'h08, 32'h200};
    sizes = '{2'd2, 2'd1, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i[0], addrs[i], sizes[i], 1'b0, 32'hFFFFFFFF);
      checks++;
      if (obsErr !== 1'b1 || obsRdata !== 32'h0 || obsLat !== 1 || obsWe + obsRe !== 0) begin
        errors++; $display("[TB] FAIL err_case%0d: got err=%b rdata=%h lat=%0d en=%0d want 1 0 1 0",
                           i, obsErr, obsRdata, obsLat, obsWe + obsRe);
      end
    end
  endtask

  task automatic test_random();
    bit          we, uns, e;
    logic [31:0] addr, wdata, expR;
    logic [1:0]  size;
    for (int t = 0; t < 60; t++) begin
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      addr  = 32'($urandom_range(0, 32'h27F));
      if (t % 2 == 0 && size != 2'd3) addr = addr & ~32'(nBytes(size) - 1);
      wdata = $urandom;
      e     = expErr(addr, size);
      expR  = (e || we) ? 32'h0 : refLoad(addr, size, uns);
      applyStimulus(we, addr, size, uns, wdata);
      if (!e && we) refStore(addr, size, wdata);
      checks++;
      if (obsErr !== e || obsRdata !== expR || obsLat !== (e ? 1 : we ? 3 : 4)) begin
        errors++; $display("[TB] FAIL rand%0d_resp: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d (we=%b a=%h sz=%0d)",
                           t, obsErr, obsRdata, obsLat, e, expR, (e ? 1 : we ? 3 : 4), we, addr, size);
      end
      checks++;
      if (obsWe !== ((!e && we) ? 2 : 0) || obsRe !== ((!e && !we) ? 2 : 0) || obsOverlap !== 1'b0 || obsStable !== 1'b1) begin
        errors++; $display("[TB] FAIL rand%0d_enables: got we=%0d re=%0d overlap=%b stable=%b",
                           t, obsWe, obsRe, obsOverlap, obsStable);
      end
      if (!e) begin
        checks++;
        if (obsAddr !== addr[8:2] || obsBsel !== expBsel(addr, size) || (we && obsDin !== expDin(size, wdata))) begin
          errors++; $display("[TB] FAIL rand%0d_sram: got addr=%h bsel=%b din=%h want addr=%h bsel=%b din=%h",
                             t, obsAddr, obsBsel, obsDin, addr[8:2], expBsel(addr, size), expDin(size, wdata));
        end
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || {sram_addr_sel, sram_byte_sel, sram_datain} !== '0) begin
        errors++; $display("[TB] FAIL rand%0d_idle: got ready=%b rv=%b addr=%h bsel=%b din=%h",
                           t, req_ready, resp_valid, sram_addr_sel, sram_byte_sel, sram_datain);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          firstAt, secondAt, busyReady, k;
    logic [31:0] firstData, secondData, exp1, exp2;
    exp1 = refLoad(32'h10, 2'd2, 1'b0);
    exp2 = refLoad(32'h13, 2'd0, 1'b1);
    firstAt = 0; secondAt = 0; busyReady = 0;
    firstData = '0; secondData = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    @(posedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) begin req_addr = 32'h13; req_size = 2'd0; req_unsigned = 1'b1; end
      if (c == 6) req_valid = 1'b0;
      if (c <= 4 && req_ready) busyReady++;
      if (resp_valid && firstAt == 0) begin firstAt = c; firstData = resp_rdata; end
      else if (resp_valid && secondAt == 0) begin secondAt = c; secondData = resp_rdata; end
    end
    req_valid = 1'b0;
    checks++;
    if (busyReady !== 0) begin
      errors++; $display("[TB] FAIL busy_ready: got %0d ready cycles while busy want 0", busyReady);
    end
    checks++;
    if (firstAt !== 4 || firstData !== exp1) begin
      errors++; $display("[TB] FAIL b2b_first: got at=%0d data=%h want 4 %h", firstAt, firstData, exp1);
    end
    checks++;
    if (secondAt !== 9 || secondData !== exp2) begin
      errors++; $display("[TB] FAIL b2b_second: got at=%0d data=%h want 9 %h", secondAt, secondData, exp2);
    end
  endtask

  task automatic test_reset_mid_op();
    int seen, k;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_size = 2'd2; req_wdata = 32'h11223344;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (sram_write_enable !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_we_before: got %b want 1", sram_write_enable);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sram_write_enable !== 1'b0 || sram_read_enable !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_async_drop: got we=%b re=%b rv=%b want 0 0 0",
                         sram_write_enable, sram_read_enable, resp_valid);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checks++;
    if (seen !== 0 || req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_no_resp: got %0d responses ready=%b want 0 1", seen, req_ready);
    end
    applyStimulus(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    checks++;
    if (obsRdata !== refLoad(32'h10, 2'd2, 1'b0) || obsLat !== 4) begin
      errors++; $display("[TB] FAIL mid_recover: got %h lat=%0d want %h 4", obsRdata, obsLat, refLoad(32'h10, 2'd2, 1'b0));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 128; i++) sramMem[i] = '0;
    for (int i = 0; i < 512; i++) refMem[i] = '0;
    sram_dataout = '0;
    test_reset();
    test_store_load();
    test_errors();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_lsu_ctrl.md
Name: sram_lsu_ctrl

Overview:
- Load/store front-end sitting directly upstream of the 128x32 word-addressed SRAM macro.
- Accepts one byte/half/word load or store per transaction from the core over a valid/ready request interface.
- Translates it into SRAM word address, byte-lane enables, lane-replicated write data and timed read/write enables.
- Returns aligned, sign- or zero-extended load data, or a store acknowledge, on a one-cycle response strobe.

Parameters:
- DEPTH, 128, number of 32-bit SRAM words.
- ADDR_W, 7, SRAM word-address width (log2 DEPTH).
- BASE_ADDR, 32'h0000_0000, byte address mapped to SRAM word 0.
- READ_LATENCY, 2, cycles read_enable/addr are held so SRAM dataout is valid.
- WRITE_LATENCY, 2, cycles write_enable/addr/data are held to commit a write.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  formatted load data (0 for stores/errors).
- resp_err  out  1  misaligned, illegal size or out-of-range request.
- sram_addr_sel  out  ADDR_W  to SRAM addr_sel.
- sram_byte_sel  out  4  to SRAM byte_sel.
- sram_read_enable  out  1  to SRAM read_enable.
- sram_write_enable  out  1  to SRAM write_enable.
- sram_datain  out  32  to SRAM datain.
- sram_dataout  in  32  from SRAM dataout (registered in SRAM).

Behaviour:
- Reset (reset=0, async): state IDLE, all outputs 0 including req_ready. After release req_ready=1.
- req_ready = (state==IDLE); a handshake is req_valid&&req_ready at a rising edge (edge E0). Requests while busy are not accepted. No response backpressure.
- FSM: IDLE, WRITE, READ, CAPTURE, RESP.
- Request capture and decode at E0:
  - off = req_addr - BASE_ADDR.
  - Error if req_size==11, half with off[0]!=0, word with off[1:0]!=0, req_addr<BASE_ADDR, or off>=4*DEPTH.
  - On error: go to RESP with resp_err=1 and resp_rdata=0; no SRAM enable is ever asserted. resp_valid is high in the cycle after E0.
- Word address: sram_addr_sel = off[ADDR_W+1:2].
- Byte-lane enables:
  - byte: 4'b0001<<off[1:0].
  - half: 4'b0011<<off[1:0].
  - word: 4'b1111.
- Store data: sram_datain = {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, wdata for word.
- Store path: WRITE state drives sram_write_enable=1 for exactly WRITE_LATENCY cycles, with addr/byte_sel/datain held constant. Then RESP, where resp_valid=1, resp_err=0, resp_rdata=0. resp_valid rises WRITE_LATENCY+1 cycles after E0 (3 by default).
- Load path:
  - READ state drives sram_read_enable=1 for READ_LATENCY cycles with addr/byte_sel held.
  - CAPTURE follows for one cycle with enables low; the SRAM holds dataout.
  - At the end of CAPTURE, register the formatted data: shift sram_dataout right by 8*off[1:0], take 8/16/32 bits, then sign- or zero-extend per req_unsigned (word ignores it).
  - RESP: resp_valid=1, resp_err=0. resp_valid rises READ_LATENCY+2 cycles after E0 (4 by default).
- RESP lasts one cycle, then IDLE. resp_rdata/resp_err hold until the next response. Back-to-back issue: a new request can be accepted on the edge leaving RESP→IDLE+1.
- sram_read_enable and sram_write_enable are never high together; both are 0 in IDLE, CAPTURE and RESP. sram_addr_sel/byte_sel/datain return to 0 in IDLE.
- Reset asserted mid-transaction: enables drop immediately, no response is produced, the transaction is lost, and the FSM restarts in IDLE.
- Counter for enable hold width is wide enough for max(READ_LATENCY, WRITE_LATENCY); a latency of 1 is legal.

Test Plan:
- Reset: hold reset=0 with req_valid=1 -> all outputs 0, no SRAM enable; release -> req_ready=1 next cycle.
- Word store then load: store 0xDEADBEEF @0x10, then load word @0x10 -> write_enable high 2 cycles with addr_sel=4, byte_sel=1111; ack 3 cycles after accept. Load returns 0xDEADBEEF with resp_valid 4 cycles after accept.
- Byte store/load extension: store byte 0x80 @0x13 -> byte_sel=1000, datain=0x80808080. Signed load byte @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word load @0x10 -> 0x80ADBEEF.
- Half access: store half 0x1234 @0x22 -> byte_sel=1100, datain=0x12341234. Signed half load @0x22 -> 0x00001234.
- Errors: word @0x02, half @0x05, size=11, addr 0x200 -> resp_err=1, resp_rdata=0 one cycle after accept, no SRAM enable asserted.
- Busy/reset-mid-op: assert req_valid continuously during a load -> req_ready low and the second request is accepted only after RESP. Pull reset low during WRITE -> write_enable drops asynchronously and no resp_valid is produced.
